// File: rtl/regfile_pkg.sv
// Shared defaults and types for the scoreboarded register file.
// Bypass of same-cycle writebacks is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned NREG_DEF = 32;
    localparam int unsigned CW_DEF   = 2;
    localparam int unsigned AW_DEF   = $clog2(NREG_DEF);

    typedef logic [XLEN_DEF-1:0] xlen_t;
    typedef logic [AW_DEF-1:0]   reg_addr_t;

    localparam int unsigned CNT_MAX = (1 << CW_DEF) - 1;

    function automatic int unsigned cnt_max(input int unsigned cw);
        return (1 << cw) - 1;
    endfunction

endpackage

// File: rtl/regfile_pend_ctr.sv
// Per-register pending-write counter: counts issued-but-not-retired writes,
// saturates at its maximum and flags retirements with nothing outstanding.
module regfile_pend_ctr
    import regfile_pkg::*;
#(
    parameter int unsigned CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          sat,
    output logic          zero,
    output logic          underflow
);

    logic [CW-1:0] cnt_q, cnt_d;

    assign cnt       = cnt_q;
    assign sat       = (cnt_q == CW'(cnt_max(CW)));
    assign zero      = (cnt_q == '0);
    assign underflow = dec && zero && !clr;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && dec) begin
            cnt_d = cnt_q;
        end else if (inc) begin
            if (!sat) cnt_d = cnt_q + 1'b1;
        end else if (dec) begin
            if (!zero) cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with pending-write scoreboard; x0 reads as zero.
// Define REGFILE_BYPASS_EN to forward same-cycle writebacks to the read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned AW   = $clog2(NREG),
    parameter int unsigned NRD  = 2,
    parameter int unsigned CW   = CW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]    rd_busy,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_addr,
    output logic              iss_ready,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              err
);

    logic [XLEN-1:0] mem_q [NREG-1:1];
    logic [XLEN-1:0] mem_d [NREG-1:1];
    logic [XLEN-1:0] rdata_all [NREG];
    logic [CW-1:0]   cnt_all [NREG];
    logic [NREG-1:0] zero_all;
    logic [NREG-1:1] inc_v, dec_v, sat_v, unf_v;
    logic            err_q, err_d;
    logic [AW-1:0]   ra;

    assign rdata_all[0] = '0;
    assign cnt_all[0]   = '0;
    assign zero_all[0]  = 1'b1;

    for (genvar r = 1; r < NREG; r++) begin : g_reg
        // For r != 0, !sat is exactly iss_ready, so this is an accepted issue.
        assign inc_v[r] = iss_valid && !sat_v[r] && (iss_addr == AW'(r));
        assign dec_v[r] = wb_en && (wb_addr == AW'(r));
        assign rdata_all[r] = mem_q[r];

        regfile_pend_ctr #(
            .CW(CW)
        ) u_ctr (
            .clk      (clk),
            .rst      (rst),
            .inc      (inc_v[r]),
            .dec      (dec_v[r]),
            .clr      (flush),
            .cnt      (cnt_all[r]),
            .sat      (sat_v[r]),
            .zero     (zero_all[r]),
            .underflow(unf_v[r])
        );
    end

    assign iss_ready = (cnt_all[iss_addr] != CW'(cnt_max(CW)));
    assign err       = err_q;

    always_comb begin
        mem_d = mem_q;
        for (int r = 1; r < NREG; r++) begin
            if (dec_v[r]) mem_d[r] = wb_data;
        end
        err_d = err_q | (|unf_v);
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        for (int k = 0; k < NRD; k++) begin
            ra = rd_addr[k*AW +: AW];
            rd_data[k*XLEN +: XLEN] = rdata_all[ra];
            rd_busy[k]              = !zero_all[ra];
`ifdef REGFILE_BYPASS_EN
            if (wb_en && (ra == wb_addr) && (ra != '0)) begin
                rd_data[k*XLEN +: XLEN] = wb_data;
                // Busy only if another write remains after this one retires.
                rd_busy[k] = !zero_all[ra] && (cnt_all[ra] != CW'(1));
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
            err_q <= 1'b0;
        end else begin
            mem_q <= mem_d;
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default parameters, NRD = 2).
module tb_regfile_sb;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NRD  = 2;
    localparam int unsigned CW   = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_busy;
    logic                 iss_valid;
    logic [AW-1:0]        iss_addr;
    logic                 iss_ready;
    logic                 wb_en;
    logic [AW-1:0]        wb_addr;
    logic [XLEN-1:0]      wb_data;
    logic                 flush;
    logic                 err;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_sb #(
        .XLEN(XLEN),
        .NREG(NREG),
        .AW  (AW),
        .NRD (NRD),
        .CW  (CW)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .iss_valid(iss_valid),
        .iss_addr (iss_addr),
        .iss_ready(iss_ready),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .flush    (flush),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    initial begin
        iss_valid = 1'b0;
        iss_addr  = '0;
        wb_en     = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        flush     = 1'b0;
        rd_addr   = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("reset_busy", 64'(rd_busy), 64'h0);
        check("reset_iss_ready", 64'(iss_ready), 64'h1);
        check("reset_err", 64'(err), 64'h0);

        // Reset in the middle of activity clears the scoreboard immediately.
        iss_valid = 1'b1;
        iss_addr  = 5'd5;
        tick();
        set_rd(5'd5, 5'd5);
        #1;
        check("pre_rst_busy", 64'(rd_busy), 64'h3);
        rst = 1'b1;
        #1;
        check("async_rst_busy", 64'(rd_busy), 64'h0);
        tick();
        check("rst_over_issue", 64'(rd_busy), 64'h0);
        iss_valid = 1'b0;
        rst       = 1'b0;

        // Writes to x0 are discarded.
        wb_en   = 1'b1;
        wb_addr = 5'd0;
        wb_data = 32'hDEAD_BEEF;
        set_rd(5'd0, 5'd0);
        tick();
        wb_en = 1'b0;
        #1;
        check("x0_data_p0", 64'(rd_data[31:0]), 64'h0);
        check("x0_data_p1", 64'(rd_data[63:32]), 64'h0);
        check("x0_busy", 64'(rd_busy), 64'h0);
        check("x0_err", 64'(err), 64'h0);
        check("x0_iss_ready", 64'(iss_ready), 64'h1);

        // Issue then writeback on x5.
        iss_valid = 1'b1;
        iss_addr  = 5'd5;
        tick();
        iss_valid = 1'b0;
        set_rd(5'd5, 5'd0);
        #1;
        check("x5_busy", 64'(rd_busy), 64'h1);
        wb_en   = 1'b1;
        wb_addr = 5'd5;
        wb_data = 32'h1234_5678;
        tick();
        wb_en = 1'b0;
        #1;
        check("x5_data", 64'(rd_data[31:0]), 64'h1234_5678);
        check("x5_busy_after_wb", 64'(rd_busy), 64'h0);

        // Saturate x7 at three outstanding writes.
        iss_valid = 1'b1;
        iss_addr  = 5'd7;
        tick();
        check("x7_ready_cnt1", 64'(iss_ready), 64'h1);
        tick();
        check("x7_ready_cnt2", 64'(iss_ready), 64'h1);
        tick();
        check("x7_ready_sat", 64'(iss_ready), 64'h0);
        tick();
        check("x7_ready_held", 64'(iss_ready), 64'h0);
        wb_en   = 1'b1;
        wb_addr = 5'd7;
        wb_data = 32'h7;
        tick();
        wb_en     = 1'b0;
        iss_valid = 1'b0;
        set_rd(5'd7, 5'd7);
        #1;
        check("x7_ready_after_wb", 64'(iss_ready), 64'h1);
        check("x7_busy_cnt2", 64'(rd_busy), 64'h3);
        wb_en = 1'b1;
        tick();
        wb_en = 1'b0;
        #1;
        check("x7_busy_cnt1", 64'(rd_busy), 64'h3);
        wb_en = 1'b1;
        tick();
        wb_en = 1'b0;
        #1;
        check("x7_busy_cnt0", 64'(rd_busy), 64'h0);
        check("x7_err", 64'(err), 64'h0);

        // Simultaneous issue and writeback on x9 leaves the count at one.
        iss_valid = 1'b1;
        iss_addr  = 5'd9;
        tick();
        wb_en   = 1'b1;
        wb_addr = 5'd9;
        wb_data = 32'h11;
        tick();
        iss_valid = 1'b0;
        wb_en     = 1'b0;
        set_rd(5'd9, 5'd9);
        #1;
        check("x9_busy_iss_wb", 64'(rd_busy), 64'h3);
        check("x9_data_iss_wb", 64'(rd_data[63:32]), 64'h11);
        wb_en   = 1'b1;
        wb_data = 32'h22;
        tick();
        wb_en = 1'b0;
        #1;
        check("x9_busy_drained", 64'(rd_busy), 64'h0);
        check("x9_err_drained", 64'(err), 64'h0);
        check("x9_data_drained", 64'(rd_data[31:0]), 64'h22);

        // Flush with a concurrent writeback.
        iss_valid = 1'b1;
        iss_addr  = 5'd9;
        tick();
        iss_addr = 5'd6;
        tick();
        iss_valid = 1'b0;
        set_rd(5'd9, 5'd6);
        #1;
        check("pre_flush_busy", 64'(rd_busy), 64'h3);
        flush   = 1'b1;
        wb_en   = 1'b1;
        wb_addr = 5'd9;
        wb_data = 32'hA5;
        tick();
        flush = 1'b0;
        wb_en = 1'b0;
        #1;
        check("flush_busy", 64'(rd_busy), 64'h0);
        check("flush_x9_data", 64'(rd_data[31:0]), 64'hA5);
        check("flush_err", 64'(err), 64'h0);

        // Same-cycle read of a register being written back.
        iss_valid = 1'b1;
        iss_addr  = 5'd4;
        tick();
        iss_valid = 1'b0;
        set_rd(5'd4, 5'd4);
        wb_en   = 1'b1;
        wb_addr = 5'd4;
        wb_data = 32'hCAFE;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_data", 64'(rd_data[31:0]), 64'hCAFE);
        check("byp_busy", 64'(rd_busy[0]), 64'h0);
`else
        check("nobyp_data", 64'(rd_data[31:0]), 64'h0);
        check("nobyp_busy", 64'(rd_busy[0]), 64'h1);
`endif
        tick();
        wb_en = 1'b0;
        #1;
        check("x4_data_next", 64'(rd_data[31:0]), 64'hCAFE);
        check("x4_busy_next", 64'(rd_busy), 64'h0);

        // Writeback with no reservation: data lands, err is sticky.
        wb_en   = 1'b1;
        wb_addr = 5'd3;
        wb_data = 32'h1;
        tick();
        wb_en = 1'b0;
        set_rd(5'd3, 5'd3);
        #1;
        check("unf_data", 64'(rd_data[31:0]), 64'h1);
        check("unf_err", 64'(err), 64'h1);
        tick();
        tick();
        check("unf_err_sticky", 64'(err), 64'h1);
        rst = 1'b1;
        #1;
        check("unf_err_rst", 64'(err), 64'h0);
        check("rst_clears_data", 64'(rd_data[31:0]), 64'h0);
        tick();
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
